// File: rtl/ef_pwmn_pkg.sv
// ef_pwmn_pkg: register map, CONTROL/IRQ bit positions and mode encodings for ef_pwmn_apb
package ef_pwmn_pkg;
  localparam logic [15:0] ADDR_LOAD     = 16'h00;
  localparam logic [15:0] ADDR_CLKDIV   = 16'h04;
  localparam logic [15:0] ADDR_CONTROL  = 16'h08;
  localparam logic [15:0] ADDR_DEADTIME = 16'h0C;
  localparam logic [15:0] ADDR_RIS      = 16'h10;
  localparam logic [15:0] ADDR_IM       = 16'h14;
  localparam logic [15:0] ADDR_ICR      = 16'h18;
  localparam logic [15:0] ADDR_MIS      = 16'h1C;
  localparam logic [15:0] ADDR_CMP0     = 16'h20;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_SHEN = 2;
  localparam int CTRL_INV  = 8;
  localparam int IRQ_ZERO = 0;
  localparam int IRQ_TOP  = 1;
  typedef enum logic {MODE_UP = 1'b0, MODE_UPDOWN = 1'b1} mode_e;
  function automatic logic [15:0] cmp_addr(input int i);
    return ADDR_CMP0 + 16'(4 * i);
  endfunction
endpackage

// File: rtl/ef_pwmn_deadtime.sv
// ef_pwmn_deadtime: complementary output pair with rising-edge dead-time insertion
module ef_pwmn_deadtime (
  input  logic       clk,
  input  logic       rst,
  input  logic       h,
  input  logic       en,
  input  logic [7:0] DEADTIME,
  output logic       pwmH,
  output logic       pwmL
);
  logic       hp_q, ok;
  logic [7:0] cnt_q, cnt_d, age;
  // age = cycles h has held its current level, saturating
  always_comb begin
    age = (h != hp_q) ? 8'd0 : cnt_q;
    cnt_d = &age ? age : age + 8'd1;
    ok = age >= DEADTIME;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q <= 1'b0;
      cnt_q <= 8'd0;
      pwmH <= 1'b0;
      pwmL <= 1'b0;
    end else begin
      hp_q <= h;
      cnt_q <= en ? cnt_d : 8'd0;
      pwmH <= en && h && ok;
      pwmL <= en && !h && ok;
    end
  end
endmodule

// File: rtl/ef_pwmn_apb.sv
// ef_pwmn_apb: multi-channel PWM with shared prescaled up/up-down timebase, shadowed compares and APB access
module ef_pwmn_apb
  import ef_pwmn_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic [31:0]    PADDR,
  input  logic           PWRITE,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic [NCH-1:0] pwmH,
  output logic [NCH-1:0] pwmL,
  output logic           irq
);
  logic [W-1:0]   load_q, load_d, load_sh_q, load_sh_d, cnt_q, cnt_d, cnt_nx;
  logic [W-1:0]   cmp_q [NCH];
  logic [W-1:0]   cmp_d [NCH];
  logic [W-1:0]   cmp_sh_q [NCH];
  logic [W-1:0]   cmp_sh_d [NCH];
  logic [7:0]     clkdiv_q, dt_q, presc_q, presc_d;
  logic           en_q, shen_q, dn_q, dn_d;
  mode_e          mode_q;
  logic [NCH-1:0] inv_q, h;
  logic [1:0]     ris_q, ris_d, im_q, icr, ev;
  logic [15:0]    a;
  logic           wr, tick, zero_ev, top_ev, bypass, unused_bits;
  assign unused_bits = ^{PADDR[31:16], PWDATA};
  assign PREADY = 1'b1;
  assign irq = |(ris_q & im_q);
  always_comb begin
    a = PADDR[15:0];
    wr = PSEL & PENABLE & PWRITE;
    tick = en_q && presc_q == clkdiv_q;
    presc_d = (!en_q || tick) ? 8'd0 : presc_q + 8'd1;
    cnt_nx = (mode_q == MODE_UP) ? ((cnt_q >= load_q) ? '0 : cnt_q + W'(1))
           : !dn_q ? ((cnt_q < load_q) ? cnt_q + W'(1) : load_q)
           : (cnt_q == '0) ? '0 : cnt_q - W'(1);
    cnt_d = !en_q ? '0 : tick ? cnt_nx : cnt_q;
    dn_d = (!en_q || mode_q == MODE_UP) ? 1'b0 : !tick ? dn_q
         : (cnt_nx == load_q) ? 1'b1 : (cnt_nx == '0) ? 1'b0 : dn_q;
    zero_ev = tick && cnt_nx == '0;
    top_ev = tick && cnt_nx == load_q;
    ev[IRQ_ZERO] = zero_ev;
    ev[IRQ_TOP] = top_ev;
    icr = (wr && a == ADDR_ICR) ? PWDATA[1:0] : 2'b00;
    ris_d = (ris_q & ~icr) | ev;
    // shadows always track writes so enabling shadowing later never loads stale values
    bypass = !(shen_q && en_q);
    load_sh_d = (wr && a == ADDR_LOAD) ? PWDATA[W-1:0] : load_sh_q;
    load_d = (wr && a == ADDR_LOAD && bypass) ? PWDATA[W-1:0]
           : (zero_ev && !bypass) ? load_sh_q : load_q;
    for (int i = 0; i < NCH; i++) begin
      cmp_sh_d[i] = (wr && a == cmp_addr(i)) ? PWDATA[W-1:0] : cmp_sh_q[i];
      cmp_d[i] = (wr && a == cmp_addr(i) && bypass) ? PWDATA[W-1:0]
               : (zero_ev && !bypass) ? cmp_sh_q[i] : cmp_q[i];
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      load_q <= '0;
      load_sh_q <= '0;
      cnt_q <= '0;
      cmp_q <= '{default: '0};
      cmp_sh_q <= '{default: '0};
      clkdiv_q <= 8'd0;
      dt_q <= 8'd0;
      presc_q <= 8'd0;
      en_q <= 1'b0;
      shen_q <= 1'b0;
      dn_q <= 1'b0;
      mode_q <= MODE_UP;
      inv_q <= '0;
      ris_q <= 2'b00;
      im_q <= 2'b00;
    end else begin
      load_q <= load_d;
      load_sh_q <= load_sh_d;
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      cmp_sh_q <= cmp_sh_d;
      presc_q <= presc_d;
      dn_q <= dn_d;
      ris_q <= ris_d;
      if (wr && a == ADDR_CLKDIV) clkdiv_q <= PWDATA[7:0];
      if (wr && a == ADDR_DEADTIME) dt_q <= PWDATA[7:0];
      if (wr && a == ADDR_IM) im_q <= PWDATA[1:0];
      if (wr && a == ADDR_CONTROL) begin
        en_q <= PWDATA[CTRL_EN];
        mode_q <= mode_e'(PWDATA[CTRL_MODE]);
        shen_q <= PWDATA[CTRL_SHEN];
        inv_q <= PWDATA[CTRL_INV +: NCH];
      end
    end
  end
  always_comb begin
    PRDATA = 32'hDEADBEEF;
    case (a)
      ADDR_LOAD:     PRDATA = 32'(load_sh_q);
      ADDR_CLKDIV:   PRDATA = 32'(clkdiv_q);
      ADDR_CONTROL:  PRDATA = {16'h0, 8'(inv_q), 5'h0, shen_q, mode_q, en_q};
      ADDR_DEADTIME: PRDATA = 32'(dt_q);
      ADDR_RIS:      PRDATA = 32'(ris_q);
      ADDR_IM:       PRDATA = 32'(im_q);
      ADDR_ICR:      PRDATA = 32'h0;
      ADDR_MIS:      PRDATA = 32'(ris_q & im_q);
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) if (a == cmp_addr(i)) PRDATA = 32'(cmp_sh_q[i]);
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign h[g] = (cnt_q < cmp_q[g]) ^ inv_q[g];
    ef_pwmn_deadtime u_dt (
      .clk(PCLK),
      .rst(PRESET),
      .h(h[g]),
      .en(en_q),
      .DEADTIME(dt_q),
      .pwmH(pwmH[g]),
      .pwmL(pwmL[g])
    );
  end
endmodule

// File: tb/tb_ef_pwmn_apb.sv
// tb_ef_pwmn_apb: randomized and directed checks of ef_pwmn_apb against a per-cycle behavioural model
module tb_ef_pwmn_apb;
  localparam int NCH = 4;
  localparam int W = 16;
  logic           PCLK = 1'b0;
  logic           PRESET = 1'b1;
  logic [31:0]    PADDR = '0;
  logic [31:0]    PWDATA = '0;
  logic           PWRITE = 1'b0;
  logic           PSEL = 1'b0;
  logic           PENABLE = 1'b0;
  logic [31:0]    PRDATA;
  logic           PREADY;
  logic [NCH-1:0] pwmH, pwmL;
  logic           irq;
  int n_cmp = 0;
  int n_bad = 0;
  int m_load, m_loads, m_cd, m_dt, m_k, m_cnt;
  int m_cmp_a [NCH];
  int m_cmp_s [NCH];
  bit m_en, m_mode, m_shen;
  bit [NCH-1:0] m_inv;
  bit [1:0] m_ris, m_im;
  bit [31:0] m_hh [NCH];
  bit [31:0] m_hl [NCH];
  logic [NCH-1:0] e_h = '0;
  logic [NCH-1:0] e_l = '0;
  ef_pwmn_apb #(.NCH(NCH), .W(W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .pwmH(pwmH), .pwmL(pwmL), .irq(irq)
  );
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    {m_load, m_loads, m_cd, m_dt, m_k, m_cnt} = '0;
    {m_en, m_mode, m_shen, m_inv, m_ris, m_im} = '0;
    for (int i = 0; i < NCH; i++) begin
      m_cmp_a[i] = 0;
      m_cmp_s[i] = 0;
      m_hh[i] = '0;
      m_hl[i] = '0;
    end
  endtask
  // count after n ticks: sawtooth in up mode, triangle in up-down mode
  function automatic int cnt_of(input int n);
    int p;
    if (!m_mode) return n % (m_load + 1);
    if (m_load == 0) return 0;
    p = n % (2 * m_load);
    return (p <= m_load) ? p : 2 * m_load - p;
  endfunction
  function automatic bit zero_at(input int j);
    return m_en && ((m_k + j) % (m_cd + 1)) == 0 && cnt_of((m_k + j) / (m_cd + 1)) == 0;
  endfunction
  function automatic logic [31:0] m_read(input bit [15:0] a);
    if (a == 16'h00) return 32'(m_loads);
    if (a == 16'h04) return 32'(m_cd);
    if (a == 16'h08) return {16'h0, 8'(m_inv), 5'h0, m_shen, m_mode, m_en};
    if (a == 16'h0C) return 32'(m_dt);
    if (a == 16'h10) return 32'(m_ris);
    if (a == 16'h14) return 32'(m_im);
    if (a == 16'h18) return 32'h0;
    if (a == 16'h1C) return 32'(m_ris & m_im);
    for (int i = 0; i < NCH; i++) if (a == 16'h20 + 16'(4 * i)) return 32'(m_cmp_s[i]);
    return 32'hDEADBEEF;
  endfunction
  task automatic cyc();
    bit w, tick, zero, top, byp, ne, hb;
    bit [15:0] a;
    bit [31:0] d, msk;
    int c;
    w = PSEL && PENABLE && PWRITE;
    a = PADDR[15:0];
    d = PWDATA;
    @(posedge PCLK);
    if (PRESET) begin
      m_reset();
      e_h = '0;
      e_l = '0;
    end else begin
      msk = (32'd1 << (m_dt + 1)) - 32'd1;
      for (int i = 0; i < NCH; i++) begin
        e_h[i] = (m_hh[i] & msk) == msk;
        e_l[i] = (m_hl[i] & msk) == msk;
      end
      tick = m_en && ((m_k + 1) % (m_cd + 1)) == 0;
      c = cnt_of((m_k + 1) / (m_cd + 1));
      zero = tick && c == 0;
      top = tick && c == m_load;
      byp = !(m_shen && m_en);
      if (zero && !byp) begin
        m_load = m_loads;
        for (int i = 0; i < NCH; i++) m_cmp_a[i] = m_cmp_s[i];
      end
      if (w && a == 16'h18) m_ris &= ~d[1:0];
      m_ris |= {top, zero};
      if (m_en) m_k++;
      if (w) begin
        if (a == 16'h00) begin
          m_loads = int'(d[W-1:0]);
          if (byp) m_load = m_loads;
        end
        if (a == 16'h04) m_cd = int'(d[7:0]);
        if (a == 16'h0C) m_dt = int'(d[7:0]);
        if (a == 16'h14) m_im = d[1:0];
        if (a == 16'h08) begin
          ne = d[0];
          if (!ne || !m_en) m_k = 0;
          m_en = ne;
          m_mode = d[1];
          m_shen = d[2];
          m_inv = d[8 +: NCH];
        end
        for (int i = 0; i < NCH; i++) if (a == 16'h20 + 16'(4 * i)) begin
          m_cmp_s[i] = int'(d[W-1:0]);
          if (byp) m_cmp_a[i] = m_cmp_s[i];
        end
      end
      m_cnt = m_en ? cnt_of(m_k / (m_cd + 1)) : 0;
      for (int i = 0; i < NCH; i++) begin
        hb = (m_cnt < m_cmp_a[i]) ^ m_inv[i];
        m_hh[i] = {m_hh[i][30:0], m_en & hb};
        m_hl[i] = {m_hl[i][30:0], m_en & ~hb};
      end
    end
    #1;
    check("pwmH", pwmH, e_h);
    check("pwmL", pwmL, e_l);
    check("irq", irq, |(m_ris & m_im));
  endtask
  task automatic apb_wr(input bit [15:0] a, input bit [31:0] d);
    PADDR = {16'h0, a};
    PWDATA = d;
    PWRITE = 1'b1;
    PSEL = 1'b1;
    PENABLE = 1'b0;
    cyc();
    PENABLE = 1'b1;
    cyc();
    {PSEL, PENABLE, PWRITE} = 3'b000;
  endtask
  task automatic rd_chk(input bit [15:0] a);
    PADDR = {16'h0, a};
    PWRITE = 1'b0;
    PSEL = 1'b1;
    PENABLE = 1'b0;
    #1;
    check($sformatf("rd%02h", a), PRDATA, m_read(a));
    cyc();
    PENABLE = 1'b1;
    cyc();
    {PSEL, PENABLE} = 2'b00;
  endtask
  task automatic wr_at_zero(input bit [15:0] a, input bit [31:0] d);
    int j;
    for (j = 0; j < 300 && !zero_at(2); j++) cyc();
    check("zero_wait", 32'(zero_at(2)), 32'd1);
    apb_wr(a, d);
  endtask
  task automatic scen(input int load, cd, dt, input bit mode, shen, input bit [NCH-1:0] inv,
                      input int c0, c1, c2, c3, input bit [1:0] im, input int ncyc, input bit rnd);
    apb_wr(16'h08, 32'h0);
    apb_wr(16'h18, 32'h3);
    apb_wr(16'h00, 32'(load));
    apb_wr(16'h04, 32'(cd));
    apb_wr(16'h0C, 32'(dt));
    apb_wr(16'h14, 32'(im));
    apb_wr(16'h20, 32'(c0));
    apb_wr(16'h24, 32'(c1));
    apb_wr(16'h28, 32'(c2));
    apb_wr(16'h2C, 32'(c3));
    apb_wr(16'h08, (32'(inv) << 8) | (32'(shen) << 2) | (32'(mode) << 1) | 32'd1);
    for (int j = 0; j < ncyc; j++) begin
      if (rnd && $urandom_range(0, 15) == 0)
        apb_wr(16'h20 + 16'(4 * $urandom_range(0, NCH - 1)), 32'($urandom_range(0, load + 2)));
      else if (rnd && $urandom_range(0, 19) == 0)
        apb_wr(16'h18, 32'($urandom_range(0, 3)));
      else
        cyc();
    end
    for (int r = 0; r < 12; r++) rd_chk(16'(4 * r));
  endtask
  initial begin
    m_reset();
    cyc();
    cyc();
    PRESET = 1'b0;
    check("pready", 32'(PREADY), 32'd1);
    for (int r = 0; r < 12; r++) rd_chk(16'(4 * r));
    rd_chk(16'h40);
    scen(9, 0, 0, 0, 0, 4'h0, 3, 0, 0, 0, 2'b11, 40, 0);
    scen(4, 0, 0, 1, 0, 4'h0, 0, 2, 0, 0, 2'b10, 40, 0);
    scen(9, 0, 2, 0, 0, 4'h0, 5, 0, 0, 0, 2'b00, 40, 0);
    scen(9, 0, 0, 0, 1, 4'h0, 3, 0, 0, 0, 2'b11, 15, 0);
    apb_wr(16'h20, 32'd7);
    repeat (30) cyc();
    wr_at_zero(16'h20, 32'd2);
    repeat (30) cyc();
    scen(9, 0, 0, 0, 0, 4'h0, 3, 1, 2, 3, 2'b01, 5, 0);
    wr_at_zero(16'h18, 32'd1);
    rd_chk(16'h10);
    rd_chk(16'h1C);
    scen(0, 1, 0, 0, 0, 4'h5, 1, 0, 0, 0, 2'b11, 20, 0);
    scen(3, 2, 1, 1, 1, 4'hA, 1, 2, 3, 4, 2'b11, 40, 1);
    for (int s = 0; s < 12; s++) begin
      int ld;
      ld = $urandom_range(0, 12);
      scen(ld, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, ld + 2),
           $urandom_range(0, ld + 2), $urandom_range(0, ld + 2), $urandom_range(0, ld + 2),
           2'($urandom_range(0, 3)), 80, 1);
    end
    scen(9, 0, 0, 0, 0, 4'h0, 5, 2, 7, 9, 2'b11, 3, 0);
    for (int j = 0; j < 40 && !e_h[0]; j++) cyc();
    check("pre_reset_h0", 32'(pwmH[0]), 32'd1);
    PRESET = 1'b1;
    cyc();
    PRESET = 1'b0;
    for (int r = 0; r < 12; r++) rd_chk(16'(4 * r));
    rd_chk(16'h40);
    repeat (5) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
